// File: rtl/vfltr_line_fir.sv
// vfltr_line_fir: vertical FIR over TAPS-1 line buffers; define FLTR_SATURATE_EN to clamp instead of wrap
module vfltr_line_fir #(
  parameter int DATA_W   = 8,
  parameter int TAPS     = 7,
  parameter int LINE_LEN = 226,
  parameter int COEF_W   = 10,
  parameter int OUT_W    = 16,
  parameter int SHIFT    = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     coef_we,
  input  logic [$clog2(TAPS)-1:0]  coef_addr,
  input  logic [COEF_W-1:0]        coef_wdata,
  output logic                     out_valid,
  output logic [OUT_W-1:0]         out_data,
  output logic                     lines_ready
);
  localparam int AW = $clog2(TAPS);
  localparam int CW = $clog2(LINE_LEN);
  localparam int PW = COEF_W + DATA_W + 1;
  localparam int ACC_W = DATA_W + COEF_W + 1 + $clog2(TAPS);
  localparam int EW = (ACC_W + 1 > OUT_W + 1) ? ACC_W + 1 : OUT_W + 1;
  localparam logic signed [EW-1:0] RND = (SHIFT > 0) ? EW'(1) << (SHIFT > 0 ? SHIFT - 1 : 0) : '0;
  logic [DATA_W-1:0] mem [TAPS-1][LINE_LEN];
  logic [DATA_W-1:0] tap [TAPS];
  logic signed [COEF_W-1:0] coef [TAPS];
  logic signed [PW-1:0] prod [TAPS];
  logic [CW-1:0] col;
  logic [AW-1:0] line;
  logic s1_v, s2_v;
  logic signed [ACC_W-1:0] sum, acc;
  logic signed [EW-1:0] rnd;
  logic [OUT_W-1:0] res_o;
`ifdef FLTR_SATURATE_EN
  localparam logic signed [EW-1:0] OMAX = {{(EW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EW-1:0] OMIN = {{(EW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  logic signed [EW-1:0] res;
`endif

  assign lines_ready = line == AW'(TAPS - 1);

  // tap 0 is the live pixel; tap k is the same column k lines back
  always_comb begin
    tap[0] = in_data;
    for (int k = 1; k < TAPS; k++) tap[k] = mem[k-1][col];
  end

  // line buffers shift one line down the chain per accepted pixel (not reset)
  always_ff @(posedge clk) begin
    if (in_valid) begin
      mem[0][col] <= in_data;
      for (int k = 1; k < TAPS - 1; k++) mem[k][col] <= mem[k-1][col];
    end
  end

  // column/line position and coefficient bank
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      line <= '0;
      for (int k = 0; k < TAPS; k++) coef[k] <= '0;
    end else begin
      if (in_valid) begin
        col <= (col == CW'(LINE_LEN - 1)) ? '0 : col + 1'b1;
        if (col == CW'(LINE_LEN - 1) && !lines_ready) line <= line + 1'b1;
      end
      if (coef_we && {1'b0, coef_addr} < (AW+1)'(TAPS)) coef[coef_addr] <= coef_wdata;
    end
  end

  // S1: per-tap products; only post-warm-up pixels carry a valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v <= 1'b0;
      for (int k = 0; k < TAPS; k++) prod[k] <= '0;
    end else begin
      s1_v <= in_valid & lines_ready;
      if (in_valid)
        for (int k = 0; k < TAPS; k++) prod[k] <= PW'(coef[k]) * PW'($signed({1'b0, tap[k]}));
    end
  end

  // adder tree over all products
  always_comb begin
    sum = '0;
    for (int k = 0; k < TAPS; k++) sum = sum + ACC_W'(prod[k]);
  end

  // S2: accumulator register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_v <= 1'b0;
      acc <= '0;
    end else begin
      s2_v <= s1_v;
      acc <= sum;
    end
  end

  // round half up, arithmetic shift, then wrap or clamp to OUT_W
  always_comb begin
    rnd = EW'(acc) + RND;
`ifdef FLTR_SATURATE_EN
    res = rnd >>> SHIFT;
    res_o = (res > OMAX) ? {1'b0, {(OUT_W-1){1'b1}}} : (res < OMIN) ? {1'b1, {(OUT_W-1){1'b0}}} : res[OUT_W-1:0];
`else
    res_o = OUT_W'(rnd >>> SHIFT);
`endif
  end

  // S3: output register, data held while invalid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data <= '0;
    end else begin
      out_valid <= s2_v;
      if (s2_v) out_data <= res_o;
    end
  end
endmodule

// File: tb/tb_vfltr_line_fir.sv
// tb_vfltr_line_fir: scoreboard bench driving SHIFT=0 and SHIFT=1 instances in parallel
module tb_vfltr_line_fir;
  localparam int L = 4;
  localparam int T = 7;
  localparam int WARM = (T - 1) * L;
`ifdef FLTR_SATURATE_EN
  localparam logic [15:0] T6_EXP = 16'h7FFF;
`else
  localparam logic [15:0] T6_EXP = 16'hEB07;
`endif
  typedef struct {logic [15:0] v; int due;} exp_t;
  logic clk = 0, rst = 0, in_valid = 0, coef_we = 0;
  logic [7:0] in_data = 0;
  logic [2:0] coef_addr = 0;
  logic [9:0] coef_wdata = 0;
  logic ov [2];
  logic [15:0] od [2];
  logic lr [2];
  exp_t q [2][$];
  exp_t e_n;
  logic en_n;
  int hist [$];
  int mc [T];
  int nacc = 0, cyc = 0, n_chk = 0, n_fail = 0;

  vfltr_line_fir #(.DATA_W(8), .TAPS(T), .LINE_LEN(L), .COEF_W(10), .OUT_W(16), .SHIFT(0)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .coef_we(coef_we),
    .coef_addr(coef_addr), .coef_wdata(coef_wdata), .out_valid(ov[0]), .out_data(od[0]), .lines_ready(lr[0]));
  vfltr_line_fir #(.DATA_W(8), .TAPS(T), .LINE_LEN(L), .COEF_W(10), .OUT_W(16), .SHIFT(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .coef_we(coef_we),
    .coef_addr(coef_addr), .coef_wdata(coef_wdata), .out_valid(ov[1]), .out_data(od[1]), .lines_ready(lr[1]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] mdl(input longint acc, input int s);
    longint r;
    r = (s > 0) ? ((acc + (longint'(1) << (s - 1))) >>> s) : acc;
`ifdef FLTR_SATURATE_EN
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
`endif
    return r[15:0];
  endfunction

  task automatic step(input logic v, input logic [7:0] d, input logic we = 0,
                      input logic [2:0] a = 0, input logic signed [9:0] w = 0);
    longint acc;
    in_valid = v;
    in_data = d;
    coef_we = we;
    coef_addr = a;
    coef_wdata = w;
    check("rdy0", 32'(lr[0]), 32'(nacc >= WARM));
    check("rdy1", 32'(lr[1]), 32'(nacc >= WARM));
    if (v) begin
      hist.push_back(int'(d));
      if (nacc >= WARM) begin
        acc = 0;
        for (int k = 0; k < T; k++) acc += longint'(mc[k]) * hist[hist.size() - 1 - k * L];
        for (int i = 0; i < 2; i++) q[i].push_back('{mdl(acc, i), cyc + 3});
      end
      nacc++;
    end
    if (we && a < 3'(T)) mc[a] = int'(w);
    @(posedge clk);
    #1;
    in_valid = 0;
    coef_we = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    #1;
    for (int i = 0; i < 2; i++) begin
      check("rst_vld", 32'(ov[i]), 0);
      check("rst_data", 32'(od[i]), 0);
      check("rst_rdy", 32'(lr[i]), 0);
      q[i].delete();
    end
    hist.delete();
    nacc = 0;
    for (int k = 0; k < T; k++) mc[k] = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  task automatic load_all(input logic signed [9:0] w);
    for (int k = 0; k < T; k++) step(0, 0, 1, 3'(k), w);
  endtask

  task automatic flush();
    repeat (5) step(0, 0);
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      en_n = q[i].size() > 0 && q[i][0].due == cyc;
      check($sformatf("vld%0d", i), 32'(ov[i]), 32'(en_n));
      if (en_n) begin
        e_n = q[i].pop_front();
        if (ov[i]) check($sformatf("data%0d", i), 32'(od[i]), 32'(e_n.v));
      end
    end
  end

  initial begin
    #1;
    do_reset();
    load_all(1);
    repeat (40) step(1, 8'd10);
    flush();
    check("t1_out", 32'(od[0]), 70);
    do_reset();
    for (int k = 0; k < T; k++) step(0, 0, 1, 3'(k), 10'(k + 1));
    step(1, 8'd100);
    repeat (35) step(1, 8'd0);
    flush();
    do_reset();
    step(0, 0, 1, 3'd3, -10'sd1);
    repeat (30) step(1, 8'd5);
    flush();
    check("t3_out", 32'(od[1]), 32'h0000FFFE);
    do_reset();
    load_all(1);
    repeat (150) step(1'($urandom_range(0, 1)), 8'd10);
    flush();
    check("t4_out", 32'(od[0]), 70);
    do_reset();
    load_all(1);
    repeat (34) step(1, 8'd10);
    do_reset();
    load_all(1);
    repeat (30) step(1, 8'd10);
    flush();
    do_reset();
    load_all(511);
    repeat (28) step(1, 8'd255);
    flush();
    check("t6_out", 32'(od[0]), 32'(T6_EXP));
    step(0, 0, 1, 3'd7, 10'sd5);
    repeat (6) step(1, 8'd255, 1, 3'd0, -10'sd512);
    step(1, 8'd200, 1, 3'd3, 10'sd100);
    repeat (20) step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
    flush();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
